// File: rtl/mdio_mgmt_ctrl_if.sv
// Operation interface between the PHY management sequencer (master) and the MDIO driver (slave).
interface mdio_mgmt_ctrl_if;
   logic        op_exec;
   logic        op_rh_wl;
   logic [4:0]  op_addr;
   logic [15:0] op_wr_data;
   logic        op_done;
   logic [15:0] op_rd_data;
   logic        op_rd_ack;

   modport master (
      output op_exec, op_rh_wl, op_addr, op_wr_data,
      input  op_done, op_rd_data, op_rd_ack
   );

   modport slave (
      input  op_exec, op_rh_wl, op_addr, op_wr_data,
      output op_done, op_rd_data, op_rd_ack
   );
endinterface

// File: rtl/mdio_mgmt_ctrl.sv
// PHY management sequencer: soft reset with self-clear polling, then periodic BMSR/PHYSR
// status polling published as link_up/speed.
//
// state        | meaning
// IDLE         | poll timer running; services pending soft reset first
// RST_WR_ISSUE | BMCR write of the reset value, op_exec high
// RST_WR_WAIT  | waiting for the BMCR write to complete
// RST_RD_ISSUE | BMCR read to check the self-clearing reset bit
// RST_RD_WAIT  | waiting for the BMCR read
// BMSR_ISSUE   | BMSR read for link status
// BMSR_WAIT    | waiting for the BMSR read
// PHYSR_ISSUE  | PHYSR read for link speed
// PHYSR_WAIT   | waiting for the PHYSR read
module mdio_mgmt_ctrl #(
   parameter logic [23:0] POLL_INTERVAL = 24'd1_000_000,
   parameter logic [15:0] TIMEOUT       = 16'd4000,
   parameter logic [7:0]  RST_POLL_MAX  = 8'd50,
   parameter logic        INIT_RST      = 1'b1,
   parameter logic [4:0]  REG_BMCR      = 5'd0,
   parameter logic [4:0]  REG_BMSR      = 5'd1,
   parameter logic [4:0]  REG_PHYSR     = 5'd17,
   parameter logic [15:0] BMCR_RST_VAL  = 16'h9140
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             soft_rst_req_i,
   mdio_mgmt_ctrl_if.master op_if,
   output logic             link_up_o,
   output logic [1:0]       speed_o,
   output logic             status_valid_o,
   output logic             phy_err_o,
   output logic             busy_o
);

   typedef enum logic [3:0] {
      IDLE, RST_WR_ISSUE, RST_WR_WAIT, RST_RD_ISSUE, RST_RD_WAIT,
      BMSR_ISSUE, BMSR_WAIT, PHYSR_ISSUE, PHYSR_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] poll_cnt_q, poll_cnt_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic [7:0]  retry_q, retry_d;
   logic        rst_pend_q, rst_pend_d;
   logic        rh_wl_q, rh_wl_d;
   logic [4:0]  addr_q, addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        link_up_q, link_up_d;
   logic [1:0]  speed_q, speed_d;
   logic        sv_q, sv_d;
   logic        err_q, err_d;
   logic        is_issue, is_wait;

   assign is_issue = state_q inside {RST_WR_ISSUE, RST_RD_ISSUE, BMSR_ISSUE, PHYSR_ISSUE};
   assign is_wait  = state_q inside {RST_WR_WAIT, RST_RD_WAIT, BMSR_WAIT, PHYSR_WAIT};

   always_comb begin
      state_d    = state_q;
      poll_cnt_d = '0;
      to_cnt_d   = '0;
      retry_d    = retry_q;
      rst_pend_d = rst_pend_q | soft_rst_req_i;
      rh_wl_d    = rh_wl_q;
      addr_d     = addr_q;
      wr_data_d  = wr_data_q;
      link_up_d  = link_up_q;
      speed_d    = speed_q;
      sv_d       = 1'b0;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            if (rst_pend_q)                                state_d = RST_WR_ISSUE;
            else if (poll_cnt_q == POLL_INTERVAL - 24'd1)  state_d = BMSR_ISSUE;
            else                                           poll_cnt_d = poll_cnt_q + 24'd1;
         end
         RST_WR_ISSUE: state_d = RST_WR_WAIT;
         RST_RD_ISSUE: state_d = RST_RD_WAIT;
         BMSR_ISSUE:   state_d = BMSR_WAIT;
         PHYSR_ISSUE:  state_d = PHYSR_WAIT;
         RST_WR_WAIT: begin
            if (op_if.op_done) begin
               state_d = RST_RD_ISSUE;
               retry_d = '0;
            end
         end
         RST_RD_WAIT: begin
            if (op_if.op_done) begin
               if (!op_if.op_rd_data[15]) begin
                  state_d = IDLE;
                  err_d   = 1'b0;
               end else begin
                  retry_d = retry_q + 8'd1;
                  if (retry_q + 8'd1 == RST_POLL_MAX) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = RST_RD_ISSUE;
                  end
               end
            end
         end
         BMSR_WAIT: begin
            if (op_if.op_done) begin
               if (op_if.op_rd_ack || !op_if.op_rd_data[2]) begin
                  link_up_d = 1'b0;
                  speed_d   = 2'b00;
                  sv_d      = 1'b1;
                  state_d   = IDLE;
                  if (op_if.op_rd_ack) err_d = 1'b1;
               end else begin
                  state_d = PHYSR_ISSUE;
               end
            end
         end
         PHYSR_WAIT: begin
            if (op_if.op_done) begin
               sv_d    = 1'b1;
               state_d = IDLE;
               if (op_if.op_rd_ack) begin
                  err_d     = 1'b1;
                  link_up_d = 1'b0;
                  speed_d   = 2'b00;
               end else begin
                  err_d     = 1'b0;
                  link_up_d = 1'b1;
                  speed_d   = op_if.op_rd_data[15:14];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // op_done in the same cycle wins over the timeout
      if (is_wait && !op_if.op_done) begin
         if (to_cnt_q == TIMEOUT - 16'd1) begin
            err_d     = 1'b1;
            link_up_d = 1'b0;
            state_d   = IDLE;
         end else begin
            to_cnt_d = to_cnt_q + 16'd1;
         end
      end

      // Operation fields are loaded on the way into ISSUE and held through WAIT.
      case (state_d)
         RST_WR_ISSUE: begin
            rh_wl_d    = 1'b0;
            addr_d     = REG_BMCR;
            wr_data_d  = BMCR_RST_VAL;
            rst_pend_d = 1'b0;
            link_up_d  = 1'b0;
         end
         RST_RD_ISSUE: begin rh_wl_d = 1'b1; addr_d = REG_BMCR;  wr_data_d = '0; end
         BMSR_ISSUE:   begin rh_wl_d = 1'b1; addr_d = REG_BMSR;  wr_data_d = '0; end
         PHYSR_ISSUE:  begin rh_wl_d = 1'b1; addr_d = REG_PHYSR; wr_data_d = '0; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         poll_cnt_q <= '0;
         to_cnt_q   <= '0;
         retry_q    <= '0;
         rst_pend_q <= INIT_RST;
         rh_wl_q    <= 1'b0;
         addr_q     <= '0;
         wr_data_q  <= '0;
         link_up_q  <= 1'b0;
         speed_q    <= 2'b00;
         sv_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         poll_cnt_q <= poll_cnt_d;
         to_cnt_q   <= to_cnt_d;
         retry_q    <= retry_d;
         rst_pend_q <= rst_pend_d;
         rh_wl_q    <= rh_wl_d;
         addr_q     <= addr_d;
         wr_data_q  <= wr_data_d;
         link_up_q  <= link_up_d;
         speed_q    <= speed_d;
         sv_q       <= sv_d;
         err_q      <= err_d;
      end
   end

   assign op_if.op_exec    = is_issue;
   assign op_if.op_rh_wl   = rh_wl_q;
   assign op_if.op_addr    = addr_q;
   assign op_if.op_wr_data = wr_data_q;
   assign link_up_o        = link_up_q;
   assign speed_o          = speed_q;
   assign status_valid_o   = sv_q;
   assign phy_err_o        = err_q;
   assign busy_o           = is_issue | is_wait;

endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// Bench for mdio_mgmt_ctrl: a driver BFM answers each operation and a transaction-level
// model predicts the next operation and the published link/speed/error state.
module tb_mdio_mgmt_ctrl;
   localparam int PI  = 100;
   localparam int TO  = 200;
   localparam int RPM = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic       link_up, status_valid, phy_err, busy;
   logic [1:0] speed;

   mdio_mgmt_ctrl_if m_if ();

   mdio_mgmt_ctrl #(
      .POLL_INTERVAL(24'd100),
      .TIMEOUT      (16'd200),
      .RST_POLL_MAX (8'd3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .soft_rst_req_i(soft_rst_req),
      .op_if         (m_if),
      .link_up_o     (link_up),
      .speed_o       (speed),
      .status_valid_o(status_valid),
      .phy_err_o     (phy_err),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int sv_cnt = 0;

   logic       m_link;
   logic [1:0] m_spd;
   logic       m_err;

   always @(posedge clk) begin
      #2;
      if (status_valid) sv_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for op_exec (counting idle negedges), checks the operation is held, then answers it.
   task automatic xact(input int dly, input logic [15:0] rd, input logic ack, input bit req2,
                       input bit withhold, output logic [4:0] a, output logic rh,
                       output logic [15:0] wd, output int gap, output int nbusy);
      bit bad;
      bad = 0;
      gap = 0;
      while (!m_if.op_exec && gap < 5000) begin
         @(negedge clk);
         gap++;
      end
      if (!m_if.op_exec) begin
         chk("exec_seen", 32'(m_if.op_exec), 32'd1);
         $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
         $fatal(1, "no operation issued");
      end
      a = m_if.op_addr;
      rh = m_if.op_rh_wl;
      wd = m_if.op_wr_data;
      nbusy = 0;
      for (int k = 1; k <= (withhold ? 1000 : dly); k++) begin
         @(negedge clk);
         soft_rst_req = req2 && (k == 1 || k == 3);
         if (withhold && !busy) break;
         nbusy++;
         if (m_if.op_exec || !busy || m_if.op_addr != a || m_if.op_rh_wl != rh ||
             m_if.op_wr_data != wd) bad = 1;
      end
      soft_rst_req = 1'b0;
      chk("hold", 32'(bad), 32'd0);
      if (!withhold) begin
         m_if.op_done = 1'b1;
         m_if.op_rd_data = rd;
         m_if.op_rd_ack = ack;
         @(negedge clk);
         m_if.op_done = 1'b0;
         m_if.op_rd_ack = 1'b0;
         m_if.op_rd_data = 16'($urandom);
      end
   endtask

   task automatic op(input string tag, input logic [4:0] ea, input logic erh, input logic [15:0] ewd,
                     input int egap, input int dly, input logic [15:0] rd, input logic ack,
                     input bit req2);
      logic [4:0]  a;
      logic        rh;
      logic [15:0] wd;
      int          gap, nb;
      xact(dly, rd, ack, req2, 1'b0, a, rh, wd, gap, nb);
      chk({tag, "_addr"}, 32'(a), 32'(ea));
      chk({tag, "_rh_wl"}, 32'(rh), 32'(erh));
      if (!erh) chk({tag, "_wdata"}, 32'(wd), 32'(ewd));
      if (egap >= 0) chk({tag, "_gap"}, 32'(gap), 32'(egap));
   endtask

   task automatic chk_status(input string tag, input int sv_exp, input int sv0);
      chk({tag, "_link"}, 32'(link_up), 32'(m_link));
      chk({tag, "_speed"}, 32'(speed), 32'(m_spd));
      chk({tag, "_err"}, 32'(phy_err), 32'(m_err));
      chk({tag, "_svcnt"}, 32'(sv_cnt - sv0), 32'(sv_exp));
   endtask

   task automatic poll(input string tag, input int egap, input logic [15:0] bmsr, input logic b_nak,
                       input logic [15:0] physr, input logic p_nak, input bit req2);
      int sv0;
      sv0 = sv_cnt;
      op({tag, "_bmsr"}, 5'd1, 1'b1, 16'h0, egap, req2 ? 6 : int'($urandom_range(1, 8)),
         bmsr, b_nak, req2);
      if (b_nak || !bmsr[2]) begin
         m_link = 1'b0;
         m_spd = 2'b00;
         if (b_nak) m_err = 1'b1;
      end else begin
         op({tag, "_physr"}, 5'd17, 1'b1, 16'h0, 0, int'($urandom_range(1, 8)), physr, p_nak, 1'b0);
         if (p_nak) begin
            m_link = 1'b0;
            m_spd = 2'b00;
            m_err = 1'b1;
         end else begin
            m_link = 1'b1;
            m_spd = physr[15:14];
            m_err = 1'b0;
         end
      end
      chk_status(tag, 1, sv0);
   endtask

   task automatic rst_seq(input string tag, input int egap, input int n_stuck);
      int sv0;
      bit stuck;
      sv0 = sv_cnt;
      op({tag, "_wr"}, 5'd0, 1'b0, 16'h9140, egap, int'($urandom_range(1, 8)),
         16'($urandom), 1'b0, 1'b0);
      m_link = 1'b0;
      for (int i = 0; i < RPM; i++) begin
         stuck = (i < n_stuck);
         op({tag, "_rd"}, 5'd0, 1'b1, 16'h0, 0, int'($urandom_range(1, 8)),
            stuck ? 16'h9140 : 16'h1140, 1'b0, 1'b0);
         if (!stuck) begin
            m_err = 1'b0;
            break;
         end
         if (i == RPM - 1) m_err = 1'b1;
      end
      chk_status(tag, 0, sv0);
   endtask

   initial begin
      logic [4:0]  a;
      logic        rh;
      logic [15:0] wd;
      int          gap, nb, sv0;

      m_if.op_done = 1'b0;
      m_if.op_rd_data = 16'h0;
      m_if.op_rd_ack = 1'b0;
      m_link = 1'b0;
      m_spd = 2'b00;
      m_err = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_exec", 32'(m_if.op_exec), 32'd0);
      chk("rst_rh_wl", 32'(m_if.op_rh_wl), 32'd0);
      chk("rst_addr", 32'(m_if.op_addr), 32'd0);
      chk("rst_wdata", 32'(m_if.op_wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sv", 32'(status_valid), 32'd0);
      chk_status("rst", 0, sv_cnt);
      rst_n = 1'b1;

      rst_seq("init", -1, 1);
      poll("g1", PI, 16'h796D, 1'b0, 16'hBC00, 1'b0, 1'b0);
      poll("down", PI, 16'h7949, 1'b0, 16'h0, 1'b0, 1'b0);
      poll("nak", PI, 16'h796D, 1'b1, 16'h0, 1'b0, 1'b0);
      poll("recov", PI, 16'h796D, 1'b0, 16'h7C00, 1'b0, 1'b0);

      for (int i = 0; i < 16; i++)
         poll("rnd", PI, 16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom),
              ($urandom_range(0, 3) == 0), 1'b0);

      sv0 = sv_cnt;
      xact(0, 16'h0, 1'b0, 1'b0, 1'b1, a, rh, wd, gap, nb);
      chk("tmo_addr", 32'(a), 32'd1);
      chk("tmo_gap", 32'(gap), 32'(PI));
      chk("tmo_cycles", 32'(nb), 32'(TO));
      m_err = 1'b1;
      m_link = 1'b0;
      chk_status("tmo", 0, sv0);

      poll("pre", PI, 16'h796D, 1'b0, 16'hBC00, 1'b0, 1'b0);
      poll("req", PI, 16'h7949, 1'b0, 16'h0, 1'b0, 1'b1);
      rst_seq("swrst", 1, 0);
      poll("post", PI, 16'h796D, 1'b0, 16'h4000, 1'b0, 1'b0);

      soft_rst_req = 1'b1;
      @(negedge clk);
      soft_rst_req = 1'b0;
      rst_seq("stuck", -1, RPM);
      poll("after_stuck", PI, 16'h796D, 1'b0, 16'h7C00, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
